ccip_c1_tx_mux: RTL and testbench



---
 rtl/ccip_c1_tx_mux.sv | 240 ++++++++++++++++++++++++
 tb/tb_ccip_c1_tx_mux.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_c1_tx_mux.sv
// Two-source CCI-P C1 write merger: per-source FIFOs, packet-level round-robin, 2-cycle latency.
// Backpressure: issue stalls on sRx_c1TxAlmFull; full FIFOs drop and count, src_almfull warns early.
package ccip_c1_tx_mux_pkg;
    typedef struct packed {
        logic [5:0]  rsvd2;
        logic [1:0]  vc_sel;
        logic        sop;
        logic        rsvd1;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd0;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
    } t_c1_line;
endpackage

module ccip_c1_fifo #(
    parameter int W      = 8,
    parameter int LDEPTH = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_push,
    input  logic [W-1:0]    i_dat,
    input  logic            i_pop,
    output logic [W-1:0]    o_dat,
    output logic            o_empty,
    output logic [LDEPTH:0] o_cnt,
    output logic            o_drop
);
    localparam int DEPTH = 2**LDEPTH;

    logic [W-1:0]      r_mem [DEPTH];
    logic [LDEPTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [LDEPTH:0]   r_cnt;
    logic              w_full, w_wr, w_rd;

    assign o_empty = (r_cnt == '0);
    assign w_full  = r_cnt[LDEPTH];
    assign w_rd    = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign w_wr    = i_push && (!w_full || w_rd);
    assign o_drop  = i_push && !w_wr;
    assign o_dat   = r_mem[r_rd_ptr];
    assign o_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_dat;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module ccip_c1_tx_mux
    import ccip_c1_tx_mux_pkg::*;
#(
    parameter int LDEPTH        = 3,
    parameter int ALMFULL_SLACK = 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  t_if_ccip_c1_Tx sTx_c1_in0,
    input  t_if_ccip_c1_Tx sTx_c1_in1,
    output logic [1:0]     src_almfull,
    input  logic           sRx_c1TxAlmFull,
    output t_if_ccip_c1_Tx sTx_c1,
    output logic [1:0]     ovf,
    output logic [15:0]    drop_cnt0,
    output logic [15:0]    drop_cnt1,
    output logic           frame_err,
    output logic [31:0]    tx_lines
);
    localparam int              DEPTH  = 2**LDEPTH;
    localparam int              LW     = $bits(t_c1_line);
    localparam logic [LDEPTH:0] AF_THR = (LDEPTH+1)'(DEPTH - ALMFULL_SLACK);

    typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} t_state;

    t_state          r_state, w_state_nxt;
    t_c1_line        w_in_line [2];
    t_c1_line        w_head [2];
    t_c1_line        w_head_sel;
    logic [LDEPTH:0] w_cnt [2];
    logic [1:0]      w_in_vld, w_empty, w_drop, w_pop, w_elig;
    logic            w_sel, w_any, w_issue, w_discard;
    logic            r_rr, r_gnt;
    logic [1:0]      r_lock;
    t_if_ccip_c1_Tx  r_tx;
    logic [1:0]      r_ovf, r_almfull;
    logic [15:0]     r_drop_cnt [2];
    logic            r_frame_err;
    logic [31:0]     r_tx_lines;

    assign w_in_vld     = {sTx_c1_in1.valid, sTx_c1_in0.valid};
    assign w_in_line[0] = {sTx_c1_in0.hdr, sTx_c1_in0.data};
    assign w_in_line[1] = {sTx_c1_in1.hdr, sTx_c1_in1.data};

    for (genvar g = 0; g < 2; g++) begin : g_src
        logic [LW-1:0] w_rd_dat;

        ccip_c1_fifo #(.W(LW), .LDEPTH(LDEPTH)) u_fifo (
            .clk     (clk),
            .resetn  (resetn),
            .i_push  (w_in_vld[g]),
            .i_dat   (w_in_line[g]),
            .i_pop   (w_pop[g]),
            .o_dat   (w_rd_dat),
            .o_empty (w_empty[g]),
            .o_cnt   (w_cnt[g]),
            .o_drop  (w_drop[g])
        );

        assign w_head[g] = t_c1_line'(w_rd_dat);
        assign w_elig[g] = !w_empty[g] && !sRx_c1TxAlmFull;
    end

    // Source selection: the locked source, else first eligible from the RR pointer.
    always_comb begin
        w_any = |w_elig;
        if (r_state == S_LOCKED)  w_sel = r_gnt;
        else if (w_elig[r_rr])    w_sel = r_rr;
        else                      w_sel = ~r_rr;
        w_head_sel = w_head[w_sel];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any && w_head_sel.hdr.sop && (w_head_sel.hdr.cl_len != 2'd0))
                          w_state_nxt = S_LOCKED;
            S_LOCKED: if (w_elig[r_gnt] && (r_lock == 2'd1))
                          w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = '0;
        w_issue   = 1'b0;
        w_discard = 1'b0;
        case (r_state)
            S_IDLE: if (w_any) begin
                w_pop[w_sel] = 1'b1;
                w_issue      = w_head_sel.hdr.sop;
                w_discard    = !w_head_sel.hdr.sop;
            end
            S_LOCKED: if (w_elig[r_gnt]) begin
                w_pop[r_gnt] = 1'b1;
                w_issue      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr   <= 1'b0;
            r_gnt  <= 1'b0;
            r_lock <= 2'd0;
        end else if (w_issue) begin
            if (r_state == S_IDLE) begin
                r_rr   <= ~w_sel;
                r_gnt  <= w_sel;
                r_lock <= w_head_sel.hdr.cl_len;
            end else begin
                r_lock <= r_lock - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx <= '0;
        end else begin
            r_tx.valid <= w_issue;
            if (w_issue) begin
                r_tx.hdr  <= w_head_sel.hdr;
                r_tx.data <= w_head_sel.data;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovf         <= '0;
            r_almfull     <= '0;
            r_drop_cnt[0] <= '0;
            r_drop_cnt[1] <= '0;
            r_frame_err   <= 1'b0;
            r_tx_lines    <= '0;
        end else begin
            r_ovf <= w_drop;
            for (int i = 0; i < 2; i++) begin
                r_almfull[i] <= (w_cnt[i] >= AF_THR);
                if (w_drop[i] && (r_drop_cnt[i] != 16'hFFFF))
                    r_drop_cnt[i] <= r_drop_cnt[i] + 16'd1;
            end
            if (w_discard)  r_frame_err <= 1'b1;
            if (r_tx.valid) r_tx_lines  <= r_tx_lines + 32'd1;
        end
    end

    assign sTx_c1      = r_tx;
    assign ovf         = r_ovf;
    assign src_almfull = r_almfull;
    assign drop_cnt0   = r_drop_cnt[0];
    assign drop_cnt1   = r_drop_cnt[1];
    assign frame_err   = r_frame_err;
    assign tx_lines    = r_tx_lines;
endmodule

// File: tb/tb_ccip_c1_tx_mux.sv
// Randomized and directed bench for ccip_c1_tx_mux: queue-based reference model feeds a scoreboard.
module tb_ccip_c1_tx_mux;
    import ccip_c1_tx_mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           resetn, almf;
    t_if_ccip_c1_Tx in0, in1, tx;
    logic [1:0]     src_af, ovf;
    logic [15:0]    dc0, dc1;
    logic           ferr;
    logic [31:0]    txl;

    ccip_c1_tx_mux #(.LDEPTH(3), .ALMFULL_SLACK(2)) dut (
        .clk(clk), .resetn(resetn), .sTx_c1_in0(in0), .sTx_c1_in1(in1),
        .src_almfull(src_af), .sRx_c1TxAlmFull(almf), .sTx_c1(tx), .ovf(ovf),
        .drop_cnt0(dc0), .drop_cnt1(dc1), .frame_err(ferr), .tx_lines(txl)
    );

    int checks = 0, errors = 0;
    int seq = 0;
    int out_src[$];
    int ovf0_pulses = 0;
    bit mon_en = 0;
    t_c1_line z = '0;

    // Reference model: two bounded queues plus packet-lock bookkeeping
    t_c1_line       mq [2][$];
    t_c1_line       exp_q[$];
    bit             m_locked, m_vld, m_ferr, m_iss;
    int             m_gnt, m_rr, m_rem, m_s;
    bit [1:0]       m_ovf, m_af;
    int             m_drop [2];
    int unsigned    m_txl;
    t_c1_line       m_ln, m_e;
    t_if_ccip_c1_Tx m_in;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq[0].delete(); mq[1].delete(); exp_q.delete();
            m_locked = 0; m_vld = 0; m_ferr = 0; m_gnt = 0; m_rr = 0; m_rem = 0;
            m_ovf = 0; m_af = 0; m_drop[0] = 0; m_drop[1] = 0; m_txl = 0;
        end else begin
            m_iss = 0;
            m_s = -1;
            if (m_vld) m_txl++;
            for (int i = 0; i < 2; i++) m_af[i] = (mq[i].size() >= 6);
            m_ovf = 0;
            if (!almf) begin
                if (!m_locked) begin
                    if (mq[m_rr].size() > 0) m_s = m_rr;
                    else if (mq[1-m_rr].size() > 0) m_s = 1 - m_rr;
                    if (m_s >= 0) begin
                        m_ln = mq[m_s].pop_front();
                        if (!m_ln.hdr.sop) m_ferr = 1;
                        else begin
                            m_iss = 1;
                            exp_q.push_back(m_ln);
                            m_gnt = m_s;
                            m_rr = 1 - m_s;
                            m_rem = int'(m_ln.hdr.cl_len);
                            m_locked = (m_rem != 0);
                        end
                    end
                end else if (mq[m_gnt].size() > 0) begin
                    m_ln = mq[m_gnt].pop_front();
                    m_iss = 1;
                    exp_q.push_back(m_ln);
                    m_rem--;
                    if (m_rem == 0) m_locked = 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                m_in = (i == 0) ? in0 : in1;
                if (m_in.valid) begin
                    if (mq[i].size() < 8) mq[i].push_back({m_in.hdr, m_in.data});
                    else begin
                        m_ovf[i] = 1;
                        if (m_drop[i] < 65535) m_drop[i]++;
                    end
                end
            end
            m_vld = m_iss;
        end
    end

    always @(negedge clk) begin
        if (resetn && mon_en) begin
            chk("valid", tx.valid, m_vld);
            chk("ovf", ovf, m_ovf);
            chk("drop_cnt0", dc0, m_drop[0]);
            chk("drop_cnt1", dc1, m_drop[1]);
            chk("frame_err", ferr, m_ferr);
            chk("tx_lines", txl, m_txl);
            chk("src_almfull", src_af, m_af);
            if (ovf[0]) ovf0_pulses++;
            if (tx.valid) begin
                out_src.push_back(int'(tx.hdr.mdata[15]));
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_line act_mdata=%0h req=none", tx.hdr.mdata);
                end else begin
                    m_e = exp_q.pop_front();
                    if (tx.hdr !== m_e.hdr || tx.data !== m_e.data) begin
                        errors++;
                        $display("FAIL out_line act_mdata=%0h act_d=%0h req_mdata=%0h req_d=%0h",
                                 tx.hdr.mdata, tx.data[31:0], m_e.hdr.mdata, m_e.data[31:0]);
                    end
                end
            end
        end
    end

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic t_c1_line mk(input int src, input bit sop, input logic [1:0] len,
                                    input logic [511:0] d);
        t_c1_line l = '0;
        l.hdr.sop     = sop;
        l.hdr.cl_len  = len;
        l.hdr.address = {10'd0, $urandom()};
        l.hdr.mdata   = {src[0], seq[14:0]};
        l.data        = d;
        seq++;
        return l;
    endfunction

    task automatic cyc(input bit v0, input t_c1_line l0, input bit v1, input t_c1_line l1);
        in0.valid = v0; in0.hdr = l0.hdr; in0.data = l0.data;
        in1.valid = v1; in1.hdr = l1.hdr; in1.data = l1.data;
        @(negedge clk);
        in0.valid = 0;
        in1.valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, z, 0, z);
    endtask

    task automatic do_reset();
        almf = 0; in0.valid = 0; in1.valid = 0;
        resetn = 0;
        repeat (2) @(negedge clk);
        resetn = 1;
        out_src.delete();
        ovf0_pulses = 0;
    endtask

    // pat bit i = expected source of the i-th issued line
    task automatic chk_src(input string nm, input int n, input logic [15:0] pat);
        chk({nm, "_cnt"}, out_src.size(), n);
        for (int i = 0; i < n; i++)
            if (i < out_src.size()) chk(nm, out_src[i], pat[i]);
    endtask

    initial begin
        int       rem [2];
        logic [1:0] plen [2];
        bit       v [2];
        t_c1_line l [2];
        logic [1:0] ln;
        bit       bad;

        in0 = '0; in1 = '0; almf = 0; resetn = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", tx.valid, 0);
        chk("rst_hdr", |tx.hdr, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_drop0", dc0, 0);
        chk("rst_drop1", dc1, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_txl", txl, 0);
        chk("rst_af", src_af, 0);
        resetn = 1;
        mon_en = 1;

        // single line, 2-cycle latency
        cyc(1, mk(0, 1, 2'd0, 512'hA5), 0, z);
        chk("t1_lat1", tx.valid, 0);
        idle(1);
        chk("t1_lat2", tx.valid, 1);
        chk("t1_data", tx.data[63:0], 64'hA5);
        idle(1);
        chk("t1_single", tx.valid, 0);
        chk("t1_txl", txl, 1);

        // 4-line batch on src0 stays contiguous against two src1 singles
        do_reset();
        cyc(1, mk(0, 1, 2'd3, rnd512()), 1, mk(1, 1, 2'd0, rnd512()));
        cyc(1, mk(0, 0, 2'd3, rnd512()), 1, mk(1, 1, 2'd0, rnd512()));
        cyc(1, mk(0, 0, 2'd3, rnd512()), 0, z);
        cyc(1, mk(0, 0, 2'd3, rnd512()), 0, z);
        idle(8);
        chk_src("t2_order", 6, 16'h0030);

        // single-line packets alternate between sources
        do_reset();
        almf = 1;
        repeat (4) cyc(1, mk(0, 1, 2'd0, rnd512()), 1, mk(1, 1, 2'd0, rnd512()));
        almf = 0;
        idle(12);
        chk_src("t3_rr", 8, 16'h00AA);

        // almost-full stall inside a batch
        do_reset();
        cyc(1, mk(0, 1, 2'd3, rnd512()), 1, mk(1, 1, 2'd0, rnd512()));
        cyc(1, mk(0, 0, 2'd3, rnd512()), 0, z);
        cyc(1, mk(0, 0, 2'd3, rnd512()), 0, z);
        almf = 1;
        cyc(1, mk(0, 0, 2'd3, rnd512()), 0, z);
        chk("t4_stall", tx.valid, 0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("t4_stall", tx.valid, 0);
        end
        almf = 0;
        idle(6);
        chk_src("t4_order", 5, 16'h0010);

        // overflow of src0 while blocked
        do_reset();
        almf = 1;
        repeat (10) cyc(1, mk(0, 1, 2'd0, rnd512()), 0, z);
        idle(1);
        chk("t5_ovf_pulses", ovf0_pulses, 2);
        chk("t5_drop0", dc0, 2);
        chk("t5_af0", src_af[0], 1);
        almf = 0;
        idle(14);
        chk("t5_lines", out_src.size(), 8);

        // sop=0 head is discarded, frame_err sticks
        do_reset();
        cyc(0, z, 1, mk(1, 0, 2'd0, rnd512()));
        cyc(0, z, 1, mk(1, 1, 2'd0, rnd512()));
        idle(3);
        chk("t6_ferr", ferr, 1);
        chk("t6_out", out_src.size(), 1);
        idle(5);
        chk("t6_ferr_sticky", ferr, 1);

        // asynchronous reset mid-batch
        cyc(1, mk(0, 1, 2'd3, rnd512()), 0, z);
        cyc(1, mk(0, 0, 2'd3, rnd512()), 0, z);
        cyc(1, mk(0, 0, 2'd3, rnd512()), 0, z);
        chk("t6_pre_valid", tx.valid, 1);
        #2 resetn = 0;
        #1;
        chk("t6_rst_valid", tx.valid, 0);
        chk("t6_rst_txl", txl, 0);
        chk("t6_rst_ferr", ferr, 0);
        @(negedge clk);
        resetn = 1;
        out_src.delete();
        idle(4);
        chk("t6_post_out", out_src.size(), 0);

        // randomized traffic
        do_reset();
        rem[0] = 0; rem[1] = 0; plen[0] = 0; plen[1] = 0;
        for (int c = 0; c < 400; c++) begin
            almf = ($urandom_range(0, 99) < 15);
            for (int i = 0; i < 2; i++) begin
                v[i] = 0;
                l[i] = z;
                if (rem[i] > 0) begin
                    if ($urandom_range(0, 3) != 0) begin
                        v[i] = 1;
                        l[i] = mk(i, 0, plen[i], rnd512());
                        rem[i]--;
                    end
                end else if (!src_af[i] && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       ln = 2'd0;
                        1:       ln = 2'd1;
                        default: ln = 2'd3;
                    endcase
                    bad = (i == 1) && ($urandom_range(0, 99) < 5);
                    v[i] = 1;
                    l[i] = mk(i, !bad, ln, rnd512());
                    plen[i] = ln;
                    rem[i] = bad ? 0 : int'(ln);
                end
            end
            cyc(v[0], l[0], v[1], l[1]);
        end
        almf = 0;
        idle(60);
        chk("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
